btn_conditioner: RTL
====================

# btn_conditioner

Input stage for the push-buttons driving the player-ship state machine and the game-restart logic. Takes raw, asynchronous, active-low board buttons; synchronises, debounces and edge-detects each one. Emits clean active-high levels plus one-cycle strobes, so downstream FSMs step exactly once per press (or per auto-repeat tick) and need no free-running throttle counter of their own.

## Interface

Parameters:
- N_BTN, 4: number of button channels (bit 0 = btn_A … bit 3 = btn_D).
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz); ≥ 2.
- REPEAT_MASK, 4'b0011: per-channel auto-repeat enable (movement buttons only).
- REPEAT_DELAY, 15000000: hold cycles from press to first repeat tick; ≥ 1.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat ticks; ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_n  in  N_BTN  raw buttons, active-low, asynchronous to clk.
- level  out  N_BTN  debounced state, 1 = pressed.
- press  out  N_BTN  one-cycle strobe on accepted press.
- release  out  N_BTN  one-cycle strobe on accepted release.
- step  out  N_BTN  one-cycle strobe: press, or auto-repeat tick.

## Operation

Each channel is independent:
- **Synchroniser:** two flops, both reset to 1 (released). `s` = second flop, inverted (1 = pressed).
- **Debouncer:** state `d` (reset 0) and counter `cnt` (width `$clog2(DEBOUNCE_CYCLES)`, reset 0).
  - If `s == d`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `d <= s`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
- **Outputs:**
  - `level = d`.
  - `press` is registered and high for exactly the cycle in which `d` first reads 1.
  - `release` is registered and high for exactly the cycle in which `d` first reads 0.
- **Repeat FSM** (channels with the REPEAT_MASK bit set):
  - IDLE → DELAY on press; repeat counter cleared.
  - DELAY: counts held cycles. When REPEAT_DELAY cycles after the press cycle are reached, emit a `step` tick → REPEAT, counter cleared.
  - REPEAT: emit a `step` tick every REPEAT_PERIOD cycles.
  - Any state → IDLE on release (same cycle `level` falls). A tick due in that cycle is suppressed.
- **step:** `step = press` OR repeat tick. The two never coincide.
- Channels without the REPEAT_MASK bit set: `step == press`.

Boundary behaviour:
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no output change and restarts the count.
- Counters saturate or clear and never wrap into a false tick.
- Simultaneous presses on several channels produce simultaneous strobes.
- Reset mid-hold: all outputs go to 0 immediately. A still-held button is re-accepted as a fresh press DEBOUNCE_CYCLES+2 edges after reset deasserts.

## Timing

- Reset values: `level`, `press`, `release`, `step` = 0; all counters 0; FSM IDLE.
- Latency: if `btn_n` is low at sampling edge 0 and stays low, `level` and `press` are high after edge DEBOUNCE_CYCLES+1. Release latency is the same.
- Repeat timing: first repeat `step` is REPEAT_DELAY cycles after the press strobe; later ticks are REPEAT_PERIOD apart.
- All outputs are registered. There are no combinational paths from `btn_n`.

## Configuration

- `BTN_AUTO_REPEAT_EN` defined: repeat FSMs and counters are compiled in, behaving as above.
- `BTN_AUTO_REPEAT_EN` undefined: no repeat logic; `step` is identical to `press` on every channel. REPEAT_MASK, REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Structure

- **Package `btn_pkg`:**
  - Channel index constants BTN_LEFT=0, BTN_RIGHT=1, BTN_FIRE=2, BTN_RESTART=3.
  - Repeat FSM state typedef `rpt_state_t` {RPT_IDLE, RPT_DELAY, RPT_REPEAT}.
  - Default timing constants for 50 MHz.
- **Sub-module `btn_debounce`:** one channel covering synchroniser, debouncer, strobes and repeat FSM. Instantiated N_BTN times in a generate loop; the top handles only parameter fan-out.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, `BTN_AUTO_REPEAT_EN` defined.

- Reset with `btn_n`=4'b1111 → all outputs 0; no strobe for 50 cycles.
- `btn_n[2]` low from edge 0, held 40 cycles → `level[2]`, `press[2]` and `step[2]` high after edge 9. `press[2]` lasts one cycle; `step[2]` never repeats (mask bit 0).
- `btn_n[0]` bounce of 7-cycle low pulses separated by 1-cycle highs, ×5 → `level[0]` stays 0; no strobes.
- `btn_n[1]` held 60 cycles → `step[1]` at press cycle P, then P+20, P+25, P+30 …. Release strobe arrives 9 cycles after `btn_n[1]` returns high; no `step` in or after that cycle.
- `btn_n[0]` and `btn_n[3]` fall on the same edge → `press[0]` and `press[3]` high in the same cycle.
- Hold `btn_n[1]` low, assert `reset` mid-REPEAT for 3 cycles → outputs 0 during reset; fresh `press[1]` 10 edges after deassert.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared constants and types for the push-button input stage.
// Channel indices, repeat FSM state encoding and 50 MHz timing defaults.
package btn_pkg;

    // Channel assignment on the board connector.
    localparam int unsigned BTN_LEFT    = 0;
    localparam int unsigned BTN_RIGHT   = 1;
    localparam int unsigned BTN_FIRE    = 2;
    localparam int unsigned BTN_RESTART = 3;

    localparam int unsigned N_BTN_DEF = 4;

    // Default timing at 50 MHz: 10 ms debounce, 300 ms first repeat, 100 ms period.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_REPEAT_DELAY    = 15000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

    // Only the movement buttons auto-repeat.
    localparam logic [N_BTN_DEF-1:0] DEF_REPEAT_MASK =
        N_BTN_DEF'((1 << BTN_LEFT) | (1 << BTN_RIGHT));

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed for a counter running 0 .. n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel - synchroniser, debouncer, press/release
// strobes and, when BTN_AUTO_REPEAT_EN is defined, the auto-repeat FSM.
// The release strobe port is called rel because release is a reserved word.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic rel,
    output logic step
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            s_c;
    logic            d_q;
    logic [DB_W-1:0] cnt_q;
    logic            db_done_c;
    logic            rise_c;
    logic            fall_c;
    logic            step_src_c;
    logic            press_q;
    logic            rel_q;
    logic            step_q;

    // Two-flop synchroniser; reset to the released (high) level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    assign s_c       = ~sync_q[1];
    assign db_done_c = (s_c != d_q) && (cnt_q == DB_LAST);
    assign rise_c    = db_done_c && s_c;
    assign fall_c    = db_done_c && !s_c;

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q   <= 1'b0;
            cnt_q <= '0;
        end else if (s_c == d_q) begin
            cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
            d_q   <= s_c;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned      RPT_W       = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    rpt_state_t       rpt_q;
    rpt_state_t       rpt_d;
    logic [RPT_W-1:0] rcnt_q;
    logic [RPT_W-1:0] rcnt_d;
    logic             tick_c;

    // Repeat FSM state and hold counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_q  <= RPT_IDLE;
            rcnt_q <= '0;
        end else begin
            rpt_q  <= rpt_d;
            rcnt_q <= rcnt_d;
        end
    end

    // Repeat FSM next state; a release in the tick cycle wins and drops the tick.
    always_comb begin
        rpt_d  = rpt_q;
        rcnt_d = rcnt_q;
        tick_c = 1'b0;
        case (rpt_q)
            RPT_IDLE: begin
                if (REPEAT_EN && rise_c) begin
                    rpt_d  = RPT_DELAY;
                    rcnt_d = '0;
                end
            end
            RPT_DELAY: begin
                if (fall_c) begin
                    rpt_d  = RPT_IDLE;
                    rcnt_d = '0;
                end else if (rcnt_q == DELAY_LAST) begin
                    tick_c = 1'b1;
                    rpt_d  = RPT_REPEAT;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            RPT_REPEAT: begin
                if (fall_c) begin
                    rpt_d  = RPT_IDLE;
                    rcnt_d = '0;
                end else if (rcnt_q == PERIOD_LAST) begin
                    tick_c = 1'b1;
                    rcnt_d = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: begin
                rpt_d  = RPT_IDLE;
                rcnt_d = '0;
            end
        endcase
    end

    assign step_src_c = rise_c | tick_c;
`else
    assign step_src_c = rise_c;
`endif

    // Registered one-cycle strobes aligned with the level change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            press_q <= rise_c;
            rel_q   <= fall_c;
            step_q  <= step_src_c;
        end
    end

    assign level = d_q;
    assign press = press_q;
    assign rel   = rel_q;
    assign step  = step_q;

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_BTN independent button channels for the game FSMs.
// Auto-repeat is compiled in only when BTN_AUTO_REPEAT_EN is defined;
// otherwise step mirrors press on every channel.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned       N_BTN           = N_BTN_DEF,
    parameter int unsigned       DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [N_BTN-1:0]  REPEAT_MASK     = N_BTN'(DEF_REPEAT_MASK),
    parameter int unsigned       REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned       REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] rel,
    output logic [N_BTN-1:0] step
);

    // One conditioning channel per button.
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_MASK[i]),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .btn_n (btn_n[i]),
            .level (level[i]),
            .press (press[i]),
            .rel   (rel[i]),
            .step  (step[i])
        );
    end

endmodule
